palette_ram_mc: RTL and testbench

- Parametrised multi-channel palette RAM, the next generation of the single-chip 3×5-bit palette.
- Generalises channel count, colour width and index width, and pipelines pixel lookup on a single 32 MHz clock with a pixel clock-enable.
- Arbitrates CPU access through a req/ack handshake with a starvation guard, replacing the G-muxed direct address path.
- Sits between the tilemap/sprite colour mixer and the RGB DACs.

---
 rtl/palette_pkg.sv | 24 ++
 rtl/palette_ch_ram.sv | 32 +++
 rtl/palette_ram_mc.sv | 205 ++++++++++++++++++++
 tb/tb_palette_ram_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the multi-channel palette RAM.
package palette_pkg;

  localparam int CH_SEL_W   = 2;
  localparam int CPU_DATA_W = 16;

  // Starvation counter: 4 bits, saturating at 15.
  localparam int             CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  // CPU access sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACC  = 2'd2,
    ACK  = 2'd3
  } cpu_state_e;

  // Width of the packed pixel output bus.
  function automatic int pix_out_width(input int num_ch, input int col_w);
    return num_ch * col_w;
  endfunction

endpackage

// File: rtl/palette_ch_ram.sv
// One colour channel: single-port synchronous RAM, COL_W x 2**ADDR_W.
// Contents are not initialised; the read data register holds when en=0.
module palette_ch_ram
  import palette_pkg::*;
#(
  parameter int COL_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [COL_W-1:0]  wdata,
  output logic [COL_W-1:0]  rdata
);

  logic [COL_W-1:0] mem_q [2**ADDR_W];
  logic [COL_W-1:0] rdata_q;

  // One access per enabled cycle; a write returns the old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/palette_ram_mc.sv
// Multi-channel palette RAM with a 2-cycle pixel lookup pipeline and a
// req/ack CPU port that steals RAM cycles under a starvation guard.
// Optional build macro PALETTE_BANK_EN adds PAL_BANK and doubles depth.
module palette_ram_mc
  import palette_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int COL_W        = 5,
  parameter int IDX_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                     CLK_32M,
  input  logic                                     RESET_N,
  input  logic                                     PIX_CE,
  input  logic [IDX_W-1:0]                         PIX_IDX,
  input  logic                                     BLANK,
`ifdef PALETTE_BANK_EN
  input  logic                                     PAL_BANK,
`endif
  output logic [pix_out_width(NUM_CH, COL_W)-1:0]  PIX_OUT,
  output logic                                     PIX_VALID,
  input  logic                                     CPU_REQ,
  input  logic                                     CPU_WE,
`ifdef PALETTE_BANK_EN
  input  logic [IDX_W+2:0]                         CPU_ADDR,
`else
  input  logic [IDX_W+1:0]                         CPU_ADDR,
`endif
  input  logic [CPU_DATA_W-1:0]                    CPU_DIN,
  output logic [CPU_DATA_W-1:0]                    CPU_DOUT,
  output logic                                     CPU_ACK
);

  localparam int OUT_W = pix_out_width(NUM_CH, COL_W);
`ifdef PALETTE_BANK_EN
  localparam int RAM_AW = IDX_W + 1;
`else
  localparam int RAM_AW = IDX_W;
`endif
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Pixel-side RAM address
  logic [RAM_AW-1:0] pix_addr;
`ifdef PALETTE_BANK_EN
  assign pix_addr = {PAL_BANK, PIX_IDX};
`else
  assign pix_addr = PIX_IDX;
`endif

  // CPU request state
  cpu_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [RAM_AW+CH_SEL_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]           din_q, din_d;
  logic [CPU_DATA_W-1:0]      dout_q, dout_d;

  logic [CH_SEL_W-1:0]   sel;
  logic [RAM_AW-1:0]     entry;
  logic                  cpu_own;
  logic [COL_W-1:0]      ch_rdata [NUM_CH];
  logic [CPU_DATA_W-1:0] cpu_rdata;
  logic [OUT_W-1:0]      pix_word;

  assign sel     = addr_q[RAM_AW +: CH_SEL_W];
  assign entry   = addr_q[RAM_AW-1:0];
  assign cpu_own = (state_q == ACC);

  // Write data above COL_W is ignored.
  logic unused_din;
  generate
    if (COL_W < CPU_DATA_W) begin : g_din_unused
      assign unused_din = ^CPU_DIN[CPU_DATA_W-1:COL_W];
    end else begin : g_din_full
      assign unused_din = 1'b0;
    end
  endgenerate

  // Channel RAMs: the CPU owns every RAM in ACC, pixels otherwise.
  // A channel select with no matching RAM enables nothing.
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      palette_ch_ram #(
        .COL_W (COL_W),
        .ADDR_W(RAM_AW)
      ) u_ram (
        .clk  (CLK_32M),
        .en   (cpu_own ? (sel == CH_SEL_W'(g)) : PIX_CE),
        .we   (cpu_own && we_q && (sel == CH_SEL_W'(g))),
        .addr (cpu_own ? entry : pix_addr),
        .wdata(din_q),
        .rdata(ch_rdata[g])
      );
    end
  endgenerate

  // Select the CPU read channel; unmatched selects read as zero.
  always_comb begin
    cpu_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == CH_SEL_W'(c)) cpu_rdata = CPU_DATA_W'(ch_rdata[c]);
    end
  end

  // Pack channel read data, channel 0 in the LSBs.
  always_comb begin
    pix_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pix_word[c*COL_W +: COL_W] = ch_rdata[c];
    end
  end

  // CPU FSM next state: latch, wait for a slot, access, acknowledge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (CPU_REQ) begin
          we_d    = CPU_WE;
          addr_d  = CPU_ADDR;
          din_d   = CPU_DIN[COL_W-1:0];
          state_d = PEND;
        end
      end
      PEND: begin
        if (!PIX_CE || (cnt_q >= LIMIT)) state_d = ACC;
        else                             cnt_d   = sat_inc(cnt_q);
      end
      ACC: state_d = ACK;
      ACK: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!we_q) dout_d = cpu_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel pipeline stage inputs and output register next values.
  logic             vld_p0_q, vld_p0_d;
  logic             blank_p0_q, blank_p0_d;
  logic             drop_p0_q, drop_p0_d;
  logic             pix_valid_q, pix_valid_d;
  logic [OUT_W-1:0] pix_out_q, pix_out_d;

  // A slot that coincides with ACC is dropped and repeats the last colour.
  always_comb begin
    vld_p0_d    = PIX_CE;
    blank_p0_d  = BLANK;
    drop_p0_d   = PIX_CE && cpu_own;
    pix_valid_d = vld_p0_q;
    pix_out_d   = pix_out_q;
    if (vld_p0_q && !drop_p0_q) begin
      pix_out_d = blank_p0_q ? '0 : pix_word;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dout_q      <= '0;
      vld_p0_q    <= 1'b0;
      blank_p0_q  <= 1'b0;
      drop_p0_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      // p0: RAM read issued, slot attributes travel with it
      vld_p0_q    <= vld_p0_d;
      blank_p0_q  <= blank_p0_d;
      drop_p0_q   <= drop_p0_d;
      // p1: colour registered onto the output
      pix_valid_q <= pix_valid_d;
      pix_out_q   <= pix_out_d;
    end
  end

  // Latched request payload; only meaningful outside IDLE.
  always_ff @(posedge CLK_32M) begin
    we_q   <= we_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  assign PIX_OUT   = pix_out_q;
  assign PIX_VALID = pix_valid_q;
  assign CPU_ACK   = (state_q == ACK);
  assign CPU_DOUT  = ((state_q == ACK) && !we_q) ? cpu_rdata : dout_q;

endmodule

// File: tb/tb_palette_ram_mc.sv
// Bench for palette_ram_mc: directed tables, hand sequences and random traffic
// against a transaction-level model of the palette.
module tb_palette_ram_mc;

  localparam int NUM_CH = 3;
  localparam int COL_W  = 5;
  localparam int IDX_W  = 8;
  localparam int LIMIT  = 4;
`ifdef PALETTE_BANK_EN
  localparam int AW = IDX_W + 1;
`else
  localparam int AW = IDX_W;
`endif
  localparam int OUT_W = NUM_CH * COL_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_ce = 1'b0;
  logic [IDX_W-1:0] pix_idx = '0;
  logic             blank = 1'b0;
  logic             pal_bank = 1'b0;
  logic             cpu_req = 1'b0;
  logic             cpu_we = 1'b0;
  logic [AW+1:0]    cpu_addr = '0;
  logic [15:0]      cpu_din = '0;
  logic [OUT_W-1:0] pix_out;
  logic             pix_valid;
  logic [15:0]      cpu_dout;
  logic             cpu_ack;

  always #5 clk = ~clk;

  palette_ram_mc #(
    .NUM_CH(NUM_CH), .COL_W(COL_W), .IDX_W(IDX_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK_32M  (clk),
    .RESET_N  (rst_n),
    .PIX_CE   (pix_ce),
    .PIX_IDX  (pix_idx),
    .BLANK    (blank),
`ifdef PALETTE_BANK_EN
    .PAL_BANK (pal_bank),
`endif
    .PIX_OUT  (pix_out),
    .PIX_VALID(pix_valid),
    .CPU_REQ  (cpu_req),
    .CPU_WE   (cpu_we),
    .CPU_ADDR (cpu_addr),
    .CPU_DIN  (cpu_din),
    .CPU_DOUT (cpu_dout),
    .CPU_ACK  (cpu_ack)
  );

  typedef struct { logic we; int ch; int entry; logic [15:0] din; } txn_t;
  typedef struct { logic v; logic [OUT_W-1:0] o; } pix_t;
  typedef struct { logic we; int ch; int entry; logic [15:0] din; logic [15:0] exp_dout; } cpu_vec_t;
  typedef struct { int idx; logic blk; logic [OUT_W-1:0] exp_out; } pix_vec_t;

  // Reference model state
  logic [COL_W-1:0] mem_m [NUM_CH][2**AW];
  txn_t             cpu_q[$];
  txn_t             cur;
  pix_t             pq[$];
  int               m_phase, m_wait;
  logic [15:0]      m_dout;
  logic [OUT_W-1:0] m_out;

  int               cyc, req_cyc, obs_ack_cyc, obs_vcyc;
  logic [15:0]      obs_dout;
  logic [OUT_W-1:0] obs_pix;
  int               n_chk, n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [OUT_W-1:0] lookup(input int a);
    logic [OUT_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*COL_W +: COL_W] = mem_m[c][a];
    return r;
  endfunction

  // One clock cycle: model advances with the current inputs, outputs checked at negedge.
  task automatic tick();
    int   nxt;
    logic exp_ack;
    logic dropped;
    int   a;
    pix_t p;
    nxt = m_phase; exp_ack = 1'b0; dropped = 1'b0;
    case (m_phase)
      0: begin
        cpu_req = 1'b0;
        if (cpu_q.size() > 0) begin
          cur      = cpu_q.pop_front();
          cpu_req  = 1'b1;
          cpu_we   = cur.we;
          cpu_addr = (AW+2)'(cur.ch * (2**AW) + cur.entry);
          cpu_din  = cur.din;
          req_cyc  = cyc;
          m_wait   = 0;
          nxt      = 1;
        end
      end
      1: begin
        if (!pix_ce || m_wait >= LIMIT) nxt = 2;
        else if (m_wait < 15) m_wait++;
      end
      2: begin
        dropped = pix_ce;
        nxt     = 3;
      end
      default: begin
        exp_ack = 1'b1;
        cpu_req = 1'b0;
        if (!cur.we) m_dout = (cur.ch < NUM_CH) ? 16'(mem_m[cur.ch][cur.entry]) : 16'h0;
        nxt = 0;
      end
    endcase
`ifdef PALETTE_BANK_EN
    a = int'({pal_bank, pix_idx});
`else
    a = int'(pix_idx);
`endif
    if (pix_ce && !dropped) m_out = blank ? '0 : lookup(a);
    pq.push_back('{pix_ce, m_out});
    if (m_phase == 2 && cur.we && cur.ch < NUM_CH) mem_m[cur.ch][cur.entry] = cur.din[COL_W-1:0];
    @(negedge clk);
    check("cpu_ack", cpu_ack, exp_ack);
    check("cpu_dout", cpu_dout, m_dout);
    if (cpu_ack) begin obs_ack_cyc = cyc; obs_dout = cpu_dout; end
    if (pq.size() > 2) begin
      p = pq.pop_front();
      check("pix_valid", pix_valid, p.v);
      check("pix_out", pix_out, p.o);
    end
    if (pix_valid) begin obs_pix = pix_out; obs_vcyc = cyc; end
    @(posedge clk); #1;
    cyc++;
    m_phase = nxt;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((m_phase != 0 || cpu_q.size() > 0) && n < max) begin
      tick();
      n++;
    end
    if (m_phase != 0 || cpu_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  // Asynchronous reset: outputs must clear at once, model restarts.
  task automatic do_reset(input int ncyc);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    m_phase = 0; m_dout = '0; m_out = '0;
    cpu_q.delete();
    pq.delete();
    pq.push_back('{1'b0, '0});
    pq.push_back('{1'b0, '0});
    #2;
    check("rst_pix_out", pix_out, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    repeat (ncyc) @(posedge clk);
    #1;
    cyc += ncyc;
    rst_n = 1'b1;
  endtask

  task automatic pix_probe(input int idx, input logic blk, input logic bank,
                           input logic [OUT_W-1:0] exp, input logic [COL_W-1:0] exp_ch0,
                           input logic ch0_only);
    int c0;
    obs_vcyc = -1;
    pix_ce = 1'b1; pix_idx = IDX_W'(idx); blank = blk; pal_bank = bank;
    c0 = cyc;
    tick();
    pix_ce = 1'b0; blank = 1'b0; pal_bank = 1'b0;
    tick();
    tick();
    check("pix_latency", obs_vcyc - c0, 2);
    if (ch0_only) check("pix_ch0", obs_pix[COL_W-1:0], exp_ch0);
    else          check("pix_table", obs_pix, exp);
  endtask

  cpu_vec_t cv[11];
  pix_vec_t pv[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; obs_ack_cyc = -1; obs_vcyc = -1;
    obs_dout = '0; obs_pix = '0; m_wait = 0;
    cv[0]  = '{1'b1, 0, 'h12, 16'h001F, 16'h0000};
    cv[1]  = '{1'b1, 1, 'h12, 16'h000A, 16'h0000};
    cv[2]  = '{1'b1, 2, 'h12, 16'h0015, 16'h0000};
    cv[3]  = '{1'b0, 0, 'h12, 16'h0000, 16'h001F};
    cv[4]  = '{1'b0, 1, 'h12, 16'h0000, 16'h000A};
    cv[5]  = '{1'b0, 2, 'h12, 16'h0000, 16'h0015};
    cv[6]  = '{1'b1, 3, 'h12, 16'h0011, 16'h0015};
    cv[7]  = '{1'b0, 3, 'h12, 16'h0000, 16'h0000};
    cv[8]  = '{1'b0, 0, 'h12, 16'h0000, 16'h001F};
    cv[9]  = '{1'b1, 1, 'h12, 16'hFFEA, 16'h001F};
    cv[10] = '{1'b0, 1, 'h12, 16'h0000, 16'h000A};
    pv[0]  = '{'h12, 1'b0, 15'h555F};
    pv[1]  = '{'h12, 1'b1, 15'h0000};
    pv[2]  = '{'h12, 1'b0, 15'h555F};

    repeat (2) @(posedge clk);
    #1;
    do_reset(2);

    // Fill the entries used by random traffic so the model knows them.
    pix_ce = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int e = 0; e < 32; e++)
        cpu_q.push_back('{1'b1, c, e, 16'($urandom)});
    drain(1000);

    // CPU table: fixed 3-cycle latency, zero extension, invalid channel.
    for (int i = 0; i < 11; i++) begin
      pix_ce = 1'b0;
      obs_ack_cyc = -1;
      cpu_q.push_back('{cv[i].we, cv[i].ch, cv[i].entry, cv[i].din});
      drain(20);
      check("tbl_ack_lat", obs_ack_cyc - req_cyc, 3);
      check("tbl_dout", obs_dout, cv[i].exp_dout);
    end

    // Pixel table: latency 2 and blanking.
    for (int i = 0; i < 3; i++) pix_probe(pv[i].idx, pv[i].blk, 1'b0, pv[i].exp_out, '0, 1'b0);

    // Starvation guard with PIX_CE held high.
    pix_ce = 1'b1; pix_idx = 8'h12; blank = 1'b0;
    repeat (3) tick();
    obs_ack_cyc = -1;
    cpu_q.push_back('{1'b1, 0, 'h12, 16'h0005});
    drain(30);
    check("starve_ack_lat", obs_ack_cyc - req_cyc, 7);
    tick();
    check("preempt_hold", obs_pix, 15'h555F);
    check("preempt_vld_cyc", obs_vcyc - req_cyc, 8);
    tick();
    check("after_write", obs_pix, 15'h5545);

    // Reset while the write waits in PEND.
    pix_ce = 1'b1;
    cpu_q.push_back('{1'b1, 2, 'h12, 16'h0001});
    repeat (3) tick();
    do_reset(2);
    pix_ce = 1'b0;
    repeat (4) tick();
    obs_ack_cyc = -1;
    cpu_q.push_back('{1'b0, 2, 'h12, 16'h0000});
    drain(20);
    check("post_rst_lat", obs_ack_cyc - req_cyc, 3);
    check("post_rst_dout", obs_dout, 16'h0015);

    // Random traffic, moderate then heavy pixel load.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 400; i++) begin
        pix_ce  = ($urandom_range(0, 99) < (ph == 0 ? 60 : 95));
        pix_idx = IDX_W'($urandom_range(0, 31));
        blank   = ($urandom_range(0, 9) == 0);
        if (m_phase == 0 && cpu_q.size() == 0 && $urandom_range(0, 3) == 0)
          cpu_q.push_back('{1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 31)), 16'($urandom)});
        tick();
      end
      drain(40);
    end
    pix_ce = 1'b0; blank = 1'b0;

`ifdef PALETTE_BANK_EN
    // Bank select: same index, different bank, different colour.
    cpu_q.push_back('{1'b1, 0, 256 + 'h12, 16'h0007});
    cpu_q.push_back('{1'b1, 1, 256 + 'h12, 16'h0001});
    cpu_q.push_back('{1'b1, 2, 256 + 'h12, 16'h0002});
    cpu_q.push_back('{1'b1, 0, 'h12, 16'h0003});
    drain(40);
    pix_probe('h12, 1'b0, 1'b1, '0, 5'h07, 1'b1);
    pix_probe('h12, 1'b0, 1'b0, '0, 5'h03, 1'b1);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
